// File: rtl/data_ram_ctrl.sv
// Data-memory controller behind the MEM stage: single-port word RAM with byte-lane stores and full-word loads.
// Latency: accept in IDLE, WAIT_CYCLES wait states, access on the edge entering RESP (WAIT_CYCLES+2 cycles per access).
// Backpressure: stallreq_o holds the MEM stage until RESP; dropping mem_ce_i in WAIT aborts; DRAM_ALIGN_CHK_EN adds the misaligned-access check.
module data_ram_ctrl #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_wr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic        misalign_o
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [3:0]              cnt;
    logic [3:0]              next_cnt;
    logic                    cap_en;
    logic                    fire;

    // Request captured at accept time; the live inputs are only trusted in IDLE.
    logic [DEPTH_LOG2-1:0]   cap_idx;
    logic [3:0]              cap_sel;
    logic [31:0]             cap_data;
    logic                    cap_wr;

    // Operands of the access performed on the edge entering RESP.
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [3:0]              acc_sel;
    logic [31:0]             acc_data;
    logic                    acc_wr;
    logic                    acc_bad;
    logic                    do_write;
    logic [31:0]             rd_word;

    logic [31:0]             ram [DEPTH];

`ifdef DRAM_ALIGN_CHK_EN
    logic [1:0]              cap_off;
    logic [1:0]              acc_off;

    // Legal lane/offset pairs: full word at 0, halves at 0 or 2, single byte at its own lane.
    function automatic logic align_ok(input logic [3:0] sel, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (sel)
            4'b1111: ok = (off == 2'b00);
            4'b1100: ok = (off == 2'b00);
            4'b0011: ok = (off == 2'b10);
            4'b1000: ok = (off == 2'b00);
            4'b0100: ok = (off == 2'b01);
            4'b0010: ok = (off == 2'b10);
            4'b0001: ok = (off == 2'b11);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction
`endif

    // Upper address bits beyond the RAM depth are don't-care by design.
    logic unused_addr;
    assign unused_addr = &{1'b0, mem_addr_i};

    // Pipeline holds while a request is outstanding and not yet in its response cycle.
    assign stallreq_o = rst & mem_ce_i & (state != RESP);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: accept, count wait states, abort on a dropped request, single RESP cycle.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        cap_en     = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (mem_ce_i) begin
                    cap_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                        fire       = 1'b1;
                    end else begin
                        next_state = WAIT;
                        next_cnt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!mem_ce_i) begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    next_state = RESP;
                    fire       = 1'b1;
                end else begin
                    next_cnt = cnt - 4'd1;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    // Capture the request when it is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            cap_idx  <= mem_addr_i[DEPTH_LOG2+1:2];
            cap_sel  <= mem_sel_i;
            cap_data <= mem_data_i;
            cap_wr   <= mem_wr_i;
`ifdef DRAM_ALIGN_CHK_EN
            cap_off  <= mem_addr_i[1:0];
`endif
        end
    end

    // With zero wait states the access fires on the accept edge, so it must see the live request.
    always_comb begin
        if (state == IDLE) begin
            acc_idx  = mem_addr_i[DEPTH_LOG2+1:2];
            acc_sel  = mem_sel_i;
            acc_data = mem_data_i;
            acc_wr   = mem_wr_i;
        end else begin
            acc_idx  = cap_idx;
            acc_sel  = cap_sel;
            acc_data = cap_data;
            acc_wr   = cap_wr;
        end
    end

`ifdef DRAM_ALIGN_CHK_EN
    assign acc_off = (state == IDLE) ? mem_addr_i[1:0] : cap_off;
    assign acc_bad = ~align_ok(acc_sel, acc_off);
`else
    assign acc_bad = 1'b0;
`endif

    assign do_write = rst & fire & acc_wr & ~acc_bad;
    assign rd_word  = ram[acc_idx];

    // Byte-lane store; RAM contents survive reset, a reset edge simply suppresses the write.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_sel[i]) begin
                    ram[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
                end
            end
        end
    end

`ifdef DRAM_ALIGN_CHK_EN
    // Load data and misalign flag; a rejected access zeroes the data and flags only the RESP cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_data_o <= 32'h0;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= fire & acc_bad;
            if (fire && acc_bad) begin
                mem_data_o <= 32'h0;
            end else if (fire && !acc_wr) begin
                mem_data_o <= rd_word;
            end
        end
    end
`else
    assign misalign_o = 1'b0;

    // Load data register, held until the next completed load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_data_o <= 32'h0;
        end else if (fire && !acc_wr) begin
            mem_data_o <= rd_word;
        end
    end
`endif

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: one instance with one wait state, one with none.
// Directed stimulus; load expectations go through a scoreboard queue.
// Outputs are sampled 1ns after the falling edge, inputs driven on the falling edge.
module tb_data_ram_ctrl;

    logic        clk;
    logic        rst;
    logic        ce    [2];
    logic        wr    [2];
    logic [3:0]  sel   [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic        stall [2];
    logic        mis   [2];

    logic [31:0] model [2][1024];
    logic [31:0] last  [2];
    logic [31:0] sb    [$];
    int          passes;
    int          total;

    data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (ce[0]),
        .mem_wr_i   (wr[0]),
        .mem_sel_i  (sel[0]),
        .mem_addr_i (addr[0]),
        .mem_data_i (wd[0]),
        .mem_data_o (rd[0]),
        .stallreq_o (stall[0]),
        .misalign_o (mis[0])
    );

    data_ram_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (ce[1]),
        .mem_wr_i   (wr[1]),
        .mem_sel_i  (sel[1]),
        .mem_addr_i (addr[1]),
        .mem_data_i (wd[1]),
        .mem_data_o (rd[1]),
        .stallreq_o (stall[1]),
        .misalign_o (mis[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic bad_align(input logic [3:0] s, input logic [1:0] off);
`ifdef DRAM_ALIGN_CHK_EN
        case ({s, off})
            6'b1111_00, 6'b1100_00, 6'b0011_10,
            6'b1000_00, 6'b0100_01, 6'b0010_10, 6'b0001_11: return 1'b0;
            default: return 1'b1;
        endcase
`else
        return 1'b0 & (|{s, off});
`endif
    endfunction

    // One access on unit u; leaves the bench in that access's RESP cycle with ce still high.
    task automatic access(input int u, input logic w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, input int exp_n, input string tag);
        int   n;
        logic m;
        @(negedge clk);
        ce[u] = 1'b1; wr[u] = w; addr[u] = a; sel[u] = s; wd[u] = d;
        m = bad_align(s, a[1:0]);
        if (!w) sb.push_back(m ? 32'h0 : model[u][a[11:2]]);
        #1;
        n = 0;
        while (stall[u] === 1'b1 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_stall_cycles"}, n, exp_n);
        check({tag, "_misalign"}, {31'b0, mis[u]}, {31'b0, m});
        if (!w) begin
            last[u] = sb.pop_front();
            check({tag, "_load_data"}, rd[u], last[u]);
        end else begin
            if (m) begin
                last[u] = 32'h0;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) model[u][a[11:2]][8*i +: 8] = d[8*i +: 8];
            end
            check({tag, "_data_held"}, rd[u], last[u]);
        end
    endtask

    task automatic idle(input int u, input string tag);
        @(negedge clk);
        ce[u] = 1'b0;
        #1;
        check({tag, "_idle_stall"}, {31'b0, stall[u]}, 32'h0);
        check({tag, "_idle_misalign"}, {31'b0, mis[u]}, 32'h0);
    endtask

    initial begin
        passes = 0;
        total  = 0;
        rst    = 1'b0;
        for (int u = 0; u < 2; u++) begin
            ce[u] = 1'b1; wr[u] = 1'b0; sel[u] = 4'hF; addr[u] = 32'h0; wd[u] = 32'h0;
            last[u] = 32'h0;
        end

        // Reset with requests asserted: no stall, outputs cleared.
        repeat (3) @(negedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst_stall%0d", u), {31'b0, stall[u]}, 32'h0);
            check($sformatf("rst_data%0d", u), rd[u], 32'h0);
            check($sformatf("rst_mis%0d", u), {31'b0, mis[u]}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b1; ce[0] = 1'b0; ce[1] = 1'b0;
        #1;
        check("post_rst_stall1", {31'b0, stall[1]}, 32'h0);

        // Word store then load with one wait state.
        access(1, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 2, "t1_st");
        access(1, 1'b0, 32'h10, 4'b1111, 32'h0, 2, "t1_ld");
        idle(1, "t1");
        check("t1_hold", rd[1], 32'hDEADBEEF);

        // Single-lane store merges into an existing word.
        access(1, 1'b1, 32'h20, 4'b1111, 32'h11223344, 2, "t2_st");
        access(1, 1'b1, 32'h21, 4'b0100, 32'hAAAAAAAA, 2, "t2_lane");
        access(1, 1'b0, 32'h20, 4'b1111, 32'h0, 2, "t2_ld");
        check("t2_const", rd[1], 32'h11AA3344);
        // Empty lane mask changes nothing.
        access(1, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 2, "t2_sel0");
        access(1, 1'b0, 32'h20, 4'b1111, 32'h0, 2, "t2_ld2");
        idle(1, "t2");

        // Zero wait states: back-to-back loads stall 1,0,1,0 and return in order.
        access(0, 1'b1, 32'h0, 4'b1111, 32'hA5A5A5A5, 1, "t3_st0");
        access(0, 1'b1, 32'h4, 4'b1111, 32'h5A5A5A5A, 1, "t3_st4");
        idle(0, "t3a");
        access(0, 1'b0, 32'h0, 4'b1111, 32'h0, 1, "t3_ld0");
        access(0, 1'b0, 32'h4, 4'b1111, 32'h0, 1, "t3_ld4");
        check("t3_const", rd[0], 32'h5A5A5A5A);
        idle(0, "t3b");

        // Reset during WAIT drops the pending store.
        access(1, 1'b1, 32'h40, 4'b1111, 32'h12345678, 2, "t4_base");
        idle(1, "t4a");
        @(negedge clk);
        ce[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h40; sel[1] = 4'hF; wd[1] = 32'hCAFEF00D;
        #1;
        check("t4_stall_accept", {31'b0, stall[1]}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t4_stall_in_rst", {31'b0, stall[1]}, 32'h0);
        @(negedge clk);
        rst = 1'b1; ce[1] = 1'b0;
        #1;
        check("t4_data_cleared", rd[1], 32'h0);
        last[0] = 32'h0;
        last[1] = 32'h0;
        access(1, 1'b0, 32'h40, 4'b1111, 32'h0, 2, "t4_ld");
        check("t4_const", rd[1], 32'h12345678);
        idle(1, "t4b");

        // Request dropped in WAIT: abort, RAM and data untouched.
        @(negedge clk);
        ce[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h10; sel[1] = 4'hF; wd[1] = 32'h55555555;
        @(negedge clk);
        ce[1] = 1'b0;
        #1;
        check("t5_stall_drop", {31'b0, stall[1]}, 32'h0);
        @(negedge clk);
        #1;
        check("t5_stall_next", {31'b0, stall[1]}, 32'h0);
        check("t5_data_unchanged", rd[1], last[1]);
        access(1, 1'b0, 32'h10, 4'b1111, 32'h0, 2, "t5_ld");
        check("t5_const", rd[1], 32'hDEADBEEF);
        idle(1, "t5");

`ifdef DRAM_ALIGN_CHK_EN
        // Misaligned word store is suppressed and flagged for one cycle.
        access(1, 1'b1, 32'h30, 4'b1111, 32'h0BADF00D, 2, "t6_base");
        access(1, 1'b1, 32'h32, 4'b1111, 32'hFFFFFFFF, 2, "t6_mis");
        check("t6_mis_flag", {31'b0, mis[1]}, 32'h1);
        idle(1, "t6a");
        access(1, 1'b0, 32'h30, 4'b1111, 32'h0, 2, "t6_ld");
        check("t6_const", rd[1], 32'h0BADF00D);
        idle(1, "t6b");
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
